// File: rtl/tag_match_arbiter.sv
// Per-interface dst-MAC lookup feeding small result FIFOs, drained round-robin onto one 14-bit tag stream.
// Define TAG_MATCH_ARBITER_DROPCNT_EN to build the per-interface saturating drop counters.
module tag_match_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0][63:0] pkt_data,
  input  logic [3:0]       pkt_valid,
  input  logic [3:0]       pkt_sop,
  input  logic [3:0]       pkt_eop,
  input  logic [3:0][9:0]  pkt_channel,
  output logic [3:0]       pkt_ready,
  input  logic             tbl_wr_en,
  input  logic [1:0]       tbl_wr_idx,
  input  logic [47:0]      tbl_wr_mac,
  input  logic [1:0]       tbl_wr_port,
  input  logic             tbl_wr_valid,
  input  logic [1:0]       default_port,
  output logic [13:0]      tag_data,
  output logic             tag_valid,
  input  logic             tag_ready,
  output logic [3:0][15:0] drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  assign pkt_ready = 4'hF;

  // Forwarding table
  logic        tbl_valid [4];
  logic [47:0] tbl_mac   [4];
  logic [1:0]  tbl_port  [4];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < 4; e++) begin
        tbl_valid[e] <= 1'b0;
        tbl_mac[e]   <= '0;
        tbl_port[e]  <= '0;
      end
    end else if (tbl_wr_en) begin
      tbl_valid[tbl_wr_idx] <= tbl_wr_valid;
      tbl_mac[tbl_wr_idx]   <= tbl_wr_mac;
      tbl_port[tbl_wr_idx]  <= tbl_wr_port;
    end
  end

  // Reads registered table state, so a same-cycle write is not yet visible.
  logic [1:0] lk_port [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lk_port[i] = default_port;
      for (int e = 3; e >= 0; e--) begin
        if (tbl_valid[e] && (tbl_mac[e] == pkt_data[i][63:16])) begin
          lk_port[i] = tbl_port[e];
        end
      end
    end
  end

  // Packet capture
  logic [3:0]  sop_beat;
  logic [3:0]  eop_beat;
  logic [3:0]  open_q;
  logic [3:0]  push;
  logic [13:0] fresh    [4];
  logic [13:0] cap_q    [4];
  logic [13:0] push_dat [4];

  assign sop_beat = pkt_valid & pkt_sop;
  assign eop_beat = pkt_valid & pkt_eop;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fresh[i]    = {lk_port[i], 2'(i), pkt_channel[i]};
      push[i]     = eop_beat[i] && (sop_beat[i] || open_q[i]);
      push_dat[i] = sop_beat[i] ? fresh[i] : cap_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      open_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sop_beat[i]) begin
          open_q[i] <= !eop_beat[i];
          cap_q[i]  <= fresh[i];
        end else if (eop_beat[i]) begin
          open_q[i] <= 1'b0;
        end
      end
    end
  end

  // Result FIFOs; the entry on the output stays in its FIFO until the handshake.
  logic [13:0]   mem    [4][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [4];
  logic [PW-1:0] rd_ptr [4];
  logic [CW-1:0] count  [4];
  logic [3:0]    pop;
  logic [3:0]    accept;
  logic [3:0]    drop;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      accept[i] = push[i] && ((count[i] != FULL) || pop[i]);
      drop[i]   = push[i] && !accept[i];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) begin
        mem[i][wr_ptr[i]] <= push_dat[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({accept[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Round-robin grant; a FIFO being popped this cycle offers its second entry.
  logic [1:0]    grant_q;
  logic [1:0]    sel;
  logic [1:0]    cand;
  logic          found;
  logic          advance;
  logic [3:0]    eligible;
  logic [PW-1:0] head_ptr [4];
  logic [13:0]   head     [4];

  always_comb begin
    advance = !tag_valid || tag_ready;
    pop     = '0;
    if (tag_valid && tag_ready) pop[grant_q] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      head_ptr[j] = pop[j] ? (rd_ptr[j] + PW'(1)) : rd_ptr[j];
      head[j]     = mem[j][head_ptr[j]];
      eligible[j] = pop[j] ? (count[j] > CW'(1)) : (count[j] != '0);
    end
    found = 1'b0;
    sel   = grant_q;
    cand  = grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = grant_q + 2'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_data  <= '0;
      grant_q   <= 2'd3;
    end else if (advance) begin
      tag_valid <= found;
      if (found) begin
        tag_data <= head[sel];
        grant_q  <= sel;
      end
    end
  end

`ifdef TAG_MATCH_ARBITER_DROPCNT_EN
  logic [15:0] drop_q [4];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        drop_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drop[i] && (drop_q[i] != 16'hFFFF)) drop_q[i] <= drop_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      drop_count[i] = drop_q[i];
    end
  end
`else
  assign drop_count = '0;
  logic unused_drop;
  assign unused_drop = |drop;
`endif

  // Low 16 bits of the sop beat are payload, not part of the lookup key.
  logic unused_bits;
  assign unused_bits = ^{pkt_data[0][15:0], pkt_data[1][15:0], pkt_data[2][15:0], pkt_data[3][15:0]};

endmodule

// File: doc/tag_match_arbiter.md
TAG_MATCH_ARBITER -- requirements
Module: tag_match_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the per-interface result FIFO depth; legal values are powers of two from 2 to 16.
REQ-002 SHALL have input clock, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have inputs pkt_data[3:0] (64 each), pkt_valid[3:0], pkt_sop[3:0], pkt_eop[3:0] (1 each): tagged per-interface packet stream from the packet memory group.
REQ-005 SHALL have input pkt_channel[3:0], 10 bits each: per-interface packet tag, constant from the sop beat to the eop beat.
REQ-006 SHALL have output pkt_ready[3:0], 1 bit each: tied to 1, so the block never back-pressures.
REQ-007 SHALL have inputs tbl_wr_en (1), tbl_wr_idx (2), tbl_wr_mac (48), tbl_wr_port (2), tbl_wr_valid (1): forwarding-table write port.
REQ-008 SHALL have input default_port, 2 bits: output interface used on a lookup miss.
REQ-009 SHALL have outputs tag_data (14), tag_valid (1) and input tag_ready (1): match-result stream, {out[1:0], in[1:0], tag[9:0]}.
REQ-010 SHALL have output drop_count[3:0], 16 bits each: per-interface dropped-result counters.

Function
REQ-011 SHALL hold 4 table entries {valid, mac[47:0], port[1:0]}, all cleared on reset; a write updates entry tbl_wr_idx on the clock edge.
REQ-012 SHALL use dst MAC = pkt_data[i][63:16] of an accepted sop beat (valid & sop).
REQ-013 SHALL select the lowest-index valid entry whose mac equals dst MAC; on a miss SHALL use default_port.
REQ-014 SHALL perform the lookup with pre-write table contents when a table write and a sop beat occur in the same cycle.
REQ-015 SHALL, per interface, on a sop beat register {port, i, pkt_channel[i]} and set that interface's "open" flag.
REQ-016 SHALL, on an eop beat while open, push the registered result into interface i's FIFO and clear open.
REQ-017 SHALL, on a single-beat packet (sop and eop in the same beat), look up and push the result in that same cycle.
REQ-018 SHALL ignore an eop beat with no open packet: no push and no count.
REQ-019 SHALL, on a sop beat while already open, discard the old result and restart capture; this is not counted.
REQ-020 SHALL, on a push when the FIFO is full, drop the result and increment drop_count[i], saturating at 16'hFFFF.
REQ-021 SHALL have FIFO occupancy counters that wrap their read/write pointers modulo FIFO_DEPTH; simultaneous push and pop when full SHALL be allowed only if the pop frees the slot first (push accepted).
REQ-022 SHALL use a round-robin arbiter over non-empty FIFOs; the search starts at last_grant+1 mod 4, with last_grant reset to 3.
REQ-023 SHALL register tag_data and tag_valid; while tag_valid and !tag_ready, tag_data is held stable and no new grant is made.
REQ-024 SHALL, on tag_valid & tag_ready, pop the granted FIFO and either load the next grant in the same cycle (full throughput, 1 result/cycle) or clear tag_valid.
REQ-025 SHALL have a latency from an eop beat at cycle N to tag_valid of N+2 when the output is idle and no other FIFO has higher priority.

Reset
REQ-026 SHALL, on reset, clear tag_valid to 0, tag_data to 0, all open flags, FIFO pointers, table entries and drop_count; last_grant is set to 3.
REQ-027 SHALL discard any packet in flight on reset mid-packet; its eop after reset is ignored per REQ-018.

Configuration
REQ-028 SHALL, with macro TAG_MATCH_ARBITER_DROPCNT_EN defined, implement the drop counters per REQ-020.
REQ-029 SHALL, without TAG_MATCH_ARBITER_DROPCNT_EN, tie drop_count outputs to 0 and implement no counter flops; drop behaviour is otherwise unchanged.

Verification
REQ-030 SHALL cover: table[1]={1, 0x0A0B0C0D0E0F, port 2}, iface 1 sends 3-beat packet dst 0x0A0B0C0D0E0F, channel 5 -> tag_data=0x2405 at eop+2.
REQ-031 SHALL cover: empty table, default_port=3, iface 0 single-beat packet, channel 0x3FF -> tag_data=0x33FF.
REQ-032 SHALL cover: all 4 ifaces eop in the same cycle, tag_ready=1 -> results in iface order 0,1,2,3 on 4 consecutive cycles.
REQ-033 SHALL cover: tag_ready=0, iface 2 sends FIFO_DEPTH+3 packets -> FIFO_DEPTH results retained, drop_count[2]=3 (0 without the macro).
REQ-034 SHALL cover: stall tag_ready for 5 cycles with tag_valid high -> tag_data constant; then release -> exactly one pop.
REQ-035 SHALL cover: reset asserted between sop and eop on iface 3 -> no result emitted for that packet; tag_valid=0 the cycle after reset.
